orpheus_phase_acc: RTL

- Phase-accumulator front end of the oscillator path.
- Once per audio sample it advances a 32-bit phase by a frequency tuning word. It presents the top 16 bits as a signed angle to the downstream combinational sine stage (full scale: -32768..32767 maps to -pi..pi).
- Optional linear glide (portamento) between tuning words.
- Valid/ready output register with sticky overrun flag.

---
 rtl/orpheus_pkg.sv | 29 ++
 rtl/orpheus_lfsr16.sv | 28 ++
 rtl/orpheus_phase_acc.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/orpheus_pkg.sv
// orpheus_pkg: shared constants and types for the oscillator phase front end.
// Contents:
//   ACC_W / ANGLE_W       default accumulator and angle widths
//   angle_t / phase_t     signed angle and unsigned phase types
//   glide_state_t         increment state machine encoding
//   LFSR_SEED / LFSR_TAPS dither generator constants
//   lfsr16_next()         one step of the dither LFSR
package orpheus_pkg;

  localparam int ACC_W   = 32;
  localparam int ANGLE_W = 16;

  typedef logic signed [ANGLE_W-1:0] angle_t;
  typedef logic        [ACC_W-1:0]   phase_t;

  typedef enum logic [0:0] {
    STEADY = 1'b0,
    GLIDE  = 1'b1
  } glide_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, feedback shifted in at bit 0.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/orpheus_lfsr16.sv
// orpheus_lfsr16: 16-bit maximal-length LFSR used as the angle dither source.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset, loads LFSR_SEED
//   enable  advance one step on this cycle
//   state   current LFSR contents
module orpheus_lfsr16
  import orpheus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] state
);

  logic [15:0] state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LFSR_SEED;
    end else if (enable) begin
      state_reg <= lfsr16_next(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/orpheus_phase_acc.sv
// orpheus_phase_acc: phase accumulator feeding the combinational sine stage.
// Once per sample tick the phase advances by the current increment; the top
// ANGLE_W bits are presented as a signed angle (-pi..pi) through a
// valid/ready output register with a sticky overrun flag. An optional linear
// glide walks the increment toward a newly loaded tuning word.
//
// Build option: define ORPHEUS_PHASE_DITHER_EN to add LFSR dither to the
// truncated fraction before the angle is taken (saturating at +pi).
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_sample_tick     one-cycle strobe per audio sample
//   i_freq_word       tuning word (phase increment per sample)
//   i_freq_load       latch i_freq_word as the new target increment
//   i_phase_reset     zero the accumulator (sync / note-on)
//   o_angle           signed angle to the sine stage
//   o_angle_valid     o_angle holds an unconsumed sample
//   i_angle_ready     downstream accepts o_angle
//   o_overrun         sticky: a sample was overwritten before acceptance
//   i_overrun_clr     clear o_overrun
module orpheus_phase_acc
  import orpheus_pkg::*;
#(
  parameter int               ACC_W      = orpheus_pkg::ACC_W,
  parameter int               ANGLE_W    = orpheus_pkg::ANGLE_W,
  parameter logic [ACC_W-1:0] GLIDE_STEP = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_sample_tick,
  input  logic [ACC_W-1:0]          i_freq_word,
  input  logic                      i_freq_load,
  input  logic                      i_phase_reset,
  output logic signed [ANGLE_W-1:0] o_angle,
  output logic                      o_angle_valid,
  input  logic                      i_angle_ready,
  output logic                      o_overrun,
  input  logic                      i_overrun_clr
);

  glide_state_t       state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [ACC_W-1:0]   inc_reg, inc_next;
  logic [ACC_W-1:0]   target_reg, target_next;
  logic [ANGLE_W-1:0] angle_reg, angle_next;
  logic               valid_reg, valid_next;
  logic               overrun_reg, overrun_next;

  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   inc_stepped;
  logic [ANGLE_W-1:0] angle_new;
  logic               accept;

  // The tick always uses the increment as it stood before this edge.
  assign acc_base = i_phase_reset ? '0 : acc_reg;
  assign acc_sum  = acc_base + inc_reg;
  assign accept   = i_angle_ready && valid_reg;

  // One glide step: move toward target by at most GLIDE_STEP. Comparing the
  // remaining distance first keeps the unsigned arithmetic from overshooting
  // or wrapping.
  always_comb begin
    inc_stepped = target_reg;
    if (target_reg > inc_reg) begin
      if ((target_reg - inc_reg) > GLIDE_STEP) begin
        inc_stepped = inc_reg + GLIDE_STEP;
      end
    end else if ((inc_reg - target_reg) > GLIDE_STEP) begin
      inc_stepped = inc_reg - GLIDE_STEP;
    end
  end

  // Increment / glide state machine. A load takes priority over stepping, so
  // a load coinciding with a tick starts gliding on the following tick.
  always_comb begin
    state_next  = state_reg;
    inc_next    = inc_reg;
    target_next = target_reg;
    if (i_freq_load) begin
      target_next = i_freq_word;
      if (GLIDE_STEP == '0) begin
        inc_next   = i_freq_word;
        state_next = STEADY;
      end else begin
        state_next = (i_freq_word != inc_reg) ? GLIDE : STEADY;
      end
    end else if (i_sample_tick && (state_reg == GLIDE)) begin
      inc_next   = inc_stepped;
      state_next = (inc_stepped == target_reg) ? STEADY : GLIDE;
    end
  end

`ifdef ORPHEUS_PHASE_DITHER_EN
  localparam int FRAC_W = ACC_W - ANGLE_W;

  logic [15:0]        lfsr_state;
  logic [ACC_W-1:0]   dither_sum;
  logic [ANGLE_W-1:0] angle_trunc;
  logic [ANGLE_W-1:0] angle_dith;

  orpheus_lfsr16 u_lfsr (
    .clk    (i_clk),
    .rst    (i_rst),
    .enable (i_sample_tick),
    .state  (lfsr_state)
  );

  // Dither occupies the fraction bits only; the top LFSR bits are used.
  always_comb begin
    dither_sum  = acc_sum + {{ANGLE_W{1'b0}}, lfsr_state[15 -: FRAC_W]};
    angle_trunc = acc_sum[ACC_W-1 -: ANGLE_W];
    angle_dith  = dither_sum[ACC_W-1 -: ANGLE_W];
    // A carry out of +max would flip the angle to -pi; hold at +max instead.
    if ((angle_trunc == {1'b0, {(ANGLE_W-1){1'b1}}}) && angle_dith[ANGLE_W-1]) begin
      angle_new = angle_trunc;
    end else begin
      angle_new = angle_dith;
    end
  end
`else
  assign angle_new = acc_sum[ACC_W-1 -: ANGLE_W];
`endif

  // Accumulator and output register.
  always_comb begin
    acc_next     = acc_reg;
    angle_next   = angle_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (i_overrun_clr) begin
      overrun_next = 1'b0;
    end
    if (i_sample_tick) begin
      acc_next   = acc_sum;
      angle_next = angle_new;
      valid_next = 1'b1;
      // Overwriting an unaccepted sample; wins over a simultaneous clear.
      if (valid_reg && !i_angle_ready) begin
        overrun_next = 1'b1;
      end
    end else begin
      if (i_phase_reset) begin
        acc_next = '0;
      end
      if (accept) begin
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= STEADY;
      acc_reg     <= '0;
      inc_reg     <= '0;
      target_reg  <= '0;
      angle_reg   <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      inc_reg     <= inc_next;
      target_reg  <= target_next;
      angle_reg   <= angle_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign o_angle       = angle_reg;
  assign o_angle_valid = valid_reg;
  assign o_overrun     = overrun_reg;

endmodule
